// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM request scheduler.
package sdram_sched_pkg;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 128;
  localparam logic [15:0] BE_ALL = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RECOVER
  } sched_state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   be;
    logic [DW-1:0] wrdata;
    logic          is_wr;
  } sdram_cmd_t;

endpackage

// File: rtl/sdram_req_sched_rr_pick.sv
// Combinational round-robin selector over ports 1..N-1; bit 0 of req_i is never granted here.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Scan ptr, ptr+1, ... wrapping within 1..N-1.
    for (int k = 0; k < int'(N) - 1; k++) begin
      idx = PW'(((int'(ptr_i) - 1 + k) % (int'(N) - 1)) + 1);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_sched.sv
// Arbitrates the single SDRAM bridge port between the loader and NPORT runtime requesters.
// Optional starvation guard for ports 1..NPORT-1: define SDRAM_SCHED_STARVE_GUARD_EN.
module sdram_req_sched #(
  parameter int unsigned NPORT      = 4,
  parameter int unsigned AW         = 22,
  parameter int unsigned DW         = 128,
  parameter int unsigned STARVE_MAX = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_done,
  input  logic                init_we,
  input  logic [AW-1:0]       init_addr,
  input  logic [DW-1:0]       init_wrdata,
  output logic                init_ac,
  input  logic [NPORT-1:0]    req_rd,
  input  logic [NPORT-1:0]    req_wr,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*16-1:0] req_be,
  input  logic [NPORT*DW-1:0] req_wrdata,
  output logic [NPORT-1:0]    req_ac,
  output logic [NPORT-1:0]    req_wait,
  output logic [DW-1:0]       rd_data,
  output logic [AW-1:0]       ar_addr,
  output logic [15:0]         ar_be,
  output logic                ar_read,
  output logic                ar_write,
  output logic [DW-1:0]       ar_wrdata,
  input  logic                ar_ac,
  input  logic [DW-1:0]       ar_rddata,
  output logic                proto_err
);
  import sdram_sched_pkg::*;

  localparam int unsigned PW = $clog2(NPORT);

  sched_state_t     state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  sdram_cmd_t       cmd_q, cmd_d;
  logic             ar_read_q, ar_read_d, ar_write_q, ar_write_d;
  logic [NPORT-1:0] gnt_q, gnt_d, req_ac_q, req_ac_d, req_wait_q, req_wait_d;
  logic             init_gnt_q, init_gnt_d, init_ac_q, init_ac_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             proto_err_q, proto_err_d;

  logic [NPORT-1:0] req_any, rr_gnt, sel, starve_gnt;
  logic             rr_valid, starve_valid;
  logic [PW-1:0]    sel_idx;
  logic [AW-1:0]    sel_addr;
  logic [15:0]      sel_be;
  logic [DW-1:0]    sel_wrdata;
  logic             sel_rd, sel_wr;

  assign req_any = req_rd | req_wr;

  rr_pick #(
    .N  (NPORT),
    .PW (PW)
  ) u_rr_pick (
    .req_i   (req_any),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .valid_o (rr_valid)
  );

`ifdef SDRAM_SCHED_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]    cnt_q [NPORT];
  logic [CW-1:0]    cnt_d [NPORT];
  logic [NPORT-1:0] grant_now;

  always_comb begin
    starve_gnt   = '0;
    starve_valid = 1'b0;
    // Downward scan so the lowest starved index wins.
    for (int i = int'(NPORT) - 1; i >= 1; i--) begin
      if (cnt_q[i] == CW'(STARVE_MAX) && req_any[i]) begin
        starve_gnt    = '0;
        starve_gnt[i] = 1'b1;
        starve_valid  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_now = (state_q == IDLE && init_done) ? sel : '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0 || grant_now[i] || (state_q != IDLE && gnt_q[i]) || !req_any[i]) begin
        cnt_d[i] = '0;
      end else if (init_done && cnt_q[i] != CW'(STARVE_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NPORT); i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign starve_gnt   = '0;
  assign starve_valid = 1'b0;
`endif

  always_comb begin
    sel = '0;
    if (starve_valid)    sel    = starve_gnt;
    else if (req_any[0]) sel[0] = 1'b1;
    else if (rr_valid)   sel    = rr_gnt;
    sel_idx    = '0;
    sel_addr   = '0;
    sel_be     = '0;
    sel_wrdata = '0;
    sel_rd     = 1'b0;
    sel_wr     = 1'b0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (sel[i]) begin
        sel_idx    = PW'(i);
        sel_addr   = req_addr[i*AW +: AW];
        sel_be     = req_be[i*16 +: 16];
        sel_wrdata = req_wrdata[i*DW +: DW];
        sel_rd     = req_rd[i];
        sel_wr     = req_wr[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cmd_d       = cmd_q;
    ar_read_d   = ar_read_q;
    ar_write_d  = ar_write_q;
    gnt_d       = gnt_q;
    init_gnt_d  = init_gnt_q;
    req_ac_d    = '0;
    init_ac_d   = 1'b0;
    rd_data_d   = rd_data_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      IDLE: begin
        if (!init_done) begin
          if (init_we) begin
            cmd_d.addr   = init_addr;
            cmd_d.be     = BE_ALL;
            cmd_d.wrdata = init_wrdata;
            cmd_d.is_wr  = 1'b1;
            ar_write_d   = 1'b1;
            init_gnt_d   = 1'b1;
            gnt_d        = '0;
            state_d      = ISSUE;
          end
        end else if (|sel) begin
          cmd_d.addr   = sel_addr;
          cmd_d.be     = sel_be;
          cmd_d.wrdata = sel_wrdata;
          cmd_d.is_wr  = sel_wr;
          ar_write_d   = sel_wr;
          ar_read_d    = ~sel_wr;
          gnt_d        = sel;
          init_gnt_d   = 1'b0;
          if (sel_rd && sel_wr) proto_err_d = 1'b1;
          if (sel_idx != '0) begin
            rr_ptr_d = (sel_idx == PW'(NPORT - 1)) ? PW'(1) : sel_idx + PW'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_ac) begin
          ar_read_d  = 1'b0;
          ar_write_d = 1'b0;
          if (!cmd_q.is_wr) rd_data_d = ar_rddata;
          req_ac_d  = gnt_q;
          init_ac_d = init_gnt_q;
          state_d   = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_wait_d = req_any & ~req_ac_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(1);
      cmd_q       <= '0;
      ar_read_q   <= 1'b0;
      ar_write_q  <= 1'b0;
      gnt_q       <= '0;
      init_gnt_q  <= 1'b0;
      req_ac_q    <= '0;
      init_ac_q   <= 1'b0;
      req_wait_q  <= '0;
      rd_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_q       <= cmd_d;
      ar_read_q   <= ar_read_d;
      ar_write_q  <= ar_write_d;
      gnt_q       <= gnt_d;
      init_gnt_q  <= init_gnt_d;
      req_ac_q    <= req_ac_d;
      init_ac_q   <= init_ac_d;
      req_wait_q  <= req_wait_d;
      rd_data_q   <= rd_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ar_addr   = cmd_q.addr;
  assign ar_be     = cmd_q.be;
  assign ar_wrdata = cmd_q.wrdata;
  assign ar_read   = ar_read_q;
  assign ar_write  = ar_write_q;
  assign req_ac    = req_ac_q;
  assign init_ac   = init_ac_q;
  assign req_wait  = req_wait_q;
  assign rd_data   = rd_data_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sdram_req_sched.sv
// Scoreboard bench for sdram_req_sched: a bridge model acks strobes, a monitor checks every ac.
module tb_sdram_req_sched;
  localparam int NP = 4;
  localparam int AW = 22;
  localparam int DW = 128;

  logic             clk = 1'b0;
  logic             reset, init_done, init_we, init_ac;
  logic [AW-1:0]    init_addr;
  logic [DW-1:0]    init_wrdata;
  logic [NP-1:0]    req_rd, req_wr, req_ac, req_wait;
  logic [NP*AW-1:0] req_addr;
  logic [NP*16-1:0] req_be;
  logic [NP*DW-1:0] req_wrdata;
  logic [DW-1:0]    rd_data, ar_wrdata, ar_rddata;
  logic [AW-1:0]    ar_addr;
  logic [15:0]      ar_be;
  logic             ar_read, ar_write, ar_ac, proto_err;

  always #5 clk = ~clk;

  sdram_req_sched #(
    .NPORT      (NP),
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .init_done   (init_done),
    .init_we     (init_we),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_ac     (init_ac),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wrdata  (req_wrdata),
    .req_ac      (req_ac),
    .req_wait    (req_wait),
    .rd_data     (rd_data),
    .ar_addr     (ar_addr),
    .ar_be       (ar_be),
    .ar_read     (ar_read),
    .ar_write    (ar_write),
    .ar_wrdata   (ar_wrdata),
    .ar_ac       (ar_ac),
    .ar_rddata   (ar_rddata),
    .proto_err   (proto_err)
  );

  typedef struct {
    int            port;  // -1 = loader
    bit            is_rd;
    logic [DW-1:0] data;
  } ac_exp_t;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [15:0]   be;
    logic [DW-1:0] wrdata;
  } br_exp_t;

  ac_exp_t exp_ac[$];
  br_exp_t exp_br[$];
  int      total = 0;
  int      bad   = 0;
  int      lat   = 1;
  bit      hold[NP];

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {10'h0, a};
    return {~w, w ^ 32'h1234_5678, w | 32'hDEAD_0000, w};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_acc(input int port, input bit wr, input logic [AW-1:0] a,
                            input logic [15:0] be, input logic [DW-1:0] wd);
    ac_exp_t e;
    br_exp_t b;
    e.port = port;  e.is_rd = !wr;  e.data = mem_f(a);
    b.is_wr = wr;   b.addr = a;     b.be = be;  b.wrdata = wd;
    exp_ac.push_back(e);
    exp_br.push_back(b);
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [15:0] be, input logic [DW-1:0] wd);
    req_rd[p] = rd;
    req_wr[p] = wr;
    req_addr[p*AW +: AW]   = a;
    req_be[p*16 +: 16]     = be;
    req_wrdata[p*DW +: DW] = wd;
  endtask

  // Requesters drop their request once they see ac, unless told to keep requesting.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NP; i++) begin
      if (req_ac[i] && !hold[i]) begin
        req_rd[i] = 1'b0;
        req_wr[i] = 1'b0;
      end
    end
    if (init_ac) init_we = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_ac.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_ac.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ac_timeout: got %0d outstanding want 0", exp_ac.size());
      exp_ac.delete();
      exp_br.delete();
    end
  endtask

  // Bridge model.
  initial begin
    br_exp_t b;
    int      k;
    bit      aborted;
    ar_ac     = 1'b0;
    ar_rddata = '1;
    forever begin
      @(posedge clk);
      #3;
      if ((ar_read || ar_write) && !reset) begin
        aborted = 1'b0;
        k = 0;
        while (k < lat && !aborted) begin
          @(posedge clk);
          #3;
          if (reset || !(ar_read || ar_write)) aborted = 1'b1;
          k++;
        end
        if (!aborted) begin
          if (exp_br.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_bridge: got addr=%0h wr=%0b want none", ar_addr, ar_write);
          end else begin
            b = exp_br.pop_front();
            chk("br_write", ar_write, b.is_wr);
            chk("br_read", ar_read, !b.is_wr);
            chk("br_addr", ar_addr, b.addr);
            chk("br_be", ar_be, b.be);
            if (b.is_wr) chk("br_wrdata", ar_wrdata, b.wrdata);
          end
          ar_ac     = 1'b1;
          ar_rddata = mem_f(ar_addr);
          @(posedge clk);
          #3;
          ar_ac     = 1'b0;
          ar_rddata = '1;
        end
      end
    end
  end

  // Monitor: every ac pulse must match the head of the scoreboard.
  initial begin
    ac_exp_t     e;
    logic [NP:0] actv, expv;
    forever begin
      @(negedge clk);
      if (init_ac || req_ac != '0) begin
        if (exp_ac.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ac: got init_ac=%0b req_ac=%b want none", init_ac, req_ac);
        end else begin
          e    = exp_ac.pop_front();
          actv = {init_ac, req_ac};
          expv = (e.port < 0) ? ((NP+1)'(1) << NP) : ((NP+1)'(1) << e.port);
          chk("ac_vector", actv, expv);
          if (e.port >= 0) chk("req_wait_at_ac", req_wait[e.port], 1'b0);
          if (e.is_rd) chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;  init_done = 1'b0;  init_we = 1'b0;
    init_addr = '0;  init_wrdata = '0;
    req_rd = '0;  req_wr = '0;  req_addr = '0;  req_be = '0;  req_wrdata = '0;
    for (int i = 0; i < NP; i++) hold[i] = 1'b0;
    repeat (3) tick();
    chk("rst_ar_read", ar_read, 1'b0);
    chk("rst_ar_write", ar_write, 1'b0);
    chk("rst_ac", {init_ac, req_ac}, '0);
    chk("rst_req_wait", req_wait, '0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_ar_be", ar_be, '0);
    reset = 1'b0;

    // Loader write before init_done; a runtime read request must be ignored.
    lat = 4;
    init_addr = 22'h000010;  init_wrdata = {16{8'hA5}};  init_we = 1'b1;
    set_req(1, 1'b1, 1'b0, 22'h000111, 16'h00FF, '0);
    expect_acc(-1, 1'b1, 22'h000010, 16'hFFFF, {16{8'hA5}});
    tick();
    chk("t1_ar_write", ar_write, 1'b1);
    chk("t1_ar_read", ar_read, 1'b0);
    chk("t1_ar_be", ar_be, 16'hFFFF);
    chk("t1_wait1", req_wait[1], 1'b1);
    wait_done(40);
    repeat (6) tick();
    chk("t1_wait1_after", req_wait[1], 1'b1);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    tick();

    // Port 0 beats port 2 when both arrive together.
    init_done = 1'b1;  lat = 2;
    set_req(0, 1'b1, 1'b0, 22'h002000, 16'hFFFF, '0);
    set_req(2, 1'b1, 1'b0, 22'h002222, 16'h0F0F, '0);
    expect_acc(0, 1'b0, 22'h002000, 16'hFFFF, '0);
    expect_acc(2, 1'b0, 22'h002222, 16'h0F0F, '0);
    tick();
    chk("t2_req_wait", req_wait, 4'b0101);
    wait_done(60);
    repeat (3) tick();
    chk("t2_rd_data_held", rd_data, mem_f(22'h002222));

    // Round robin over 1..3 from a fresh pointer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 1;
    for (int p = 1; p < NP; p++) begin
      hold[p] = 1'b1;
      set_req(p, 1'b1, 1'b0, AW'(22'h003000 + p), 16'hFFFF, '0);
    end
    for (int r = 0; r < 2; r++)
      for (int p = 1; p < NP; p++) expect_acc(p, 1'b0, AW'(22'h003000 + p), 16'hFFFF, '0);
    wait_done(100);
    for (int p = 1; p < NP; p++) begin
      hold[p] = 1'b0;
      set_req(p, 1'b0, 1'b0, '0, '0, '0);
    end
    repeat (3) tick();

    // rd and wr together: issued as a write, sticky proto_err.
    chk("t4_proto_err_pre", proto_err, 1'b0);
    set_req(1, 1'b1, 1'b1, 22'h000444, 16'h3C3C, {4{32'hDEAD_BEEF}});
    expect_acc(1, 1'b1, 22'h000444, 16'h3C3C, {4{32'hDEAD_BEEF}});
    wait_done(60);
    chk("t4_proto_err", proto_err, 1'b1);
    repeat (5) tick();
    chk("t4_proto_err_sticky", proto_err, 1'b1);

    // Reset while the bridge access is in flight; the held request is reissued.
    lat = 20;
    set_req(2, 1'b1, 1'b0, 22'h000555, 16'hFFFF, '0);
    tick();
    chk("t5_ar_read_issue", ar_read, 1'b1);
    reset = 1'b1;
    lat = 2;
    tick();
    chk("t5_ar_read_rst", ar_read, 1'b0);
    chk("t5_ar_write_rst", ar_write, 1'b0);
    chk("t5_req_ac_rst", req_ac, '0);
    chk("t5_proto_err_rst", proto_err, 1'b0);
    reset = 1'b0;
    expect_acc(2, 1'b0, 22'h000555, 16'hFFFF, '0);
    wait_done(60);

    // Port 0 requesting continuously against port 1.
    lat = 1;
    hold[0] = 1'b1;
    set_req(0, 1'b1, 1'b0, 22'h000600, 16'hFFFF, '0);
    set_req(1, 1'b1, 1'b0, 22'h000601, 16'hFFFF, '0);
`ifdef SDRAM_SCHED_STARVE_GUARD_EN
    expect_acc(0, 1'b0, 22'h000600, 16'hFFFF, '0);
    expect_acc(0, 1'b0, 22'h000600, 16'hFFFF, '0);
    expect_acc(1, 1'b0, 22'h000601, 16'hFFFF, '0);
    expect_acc(0, 1'b0, 22'h000600, 16'hFFFF, '0);
    expect_acc(0, 1'b0, 22'h000600, 16'hFFFF, '0);
    wait_done(100);
    hold[0] = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
`else
    for (int r = 0; r < 5; r++) expect_acc(0, 1'b0, 22'h000600, 16'hFFFF, '0);
    wait_done(100);
    hold[0] = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    expect_acc(1, 1'b0, 22'h000601, 16'hFFFF, '0);
    wait_done(60);
`endif
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_req_sched.md
Name: sdram_req_sched

Overview:
- Schedules the single 128-bit SDRAM bridge port between the SD-card loader and N runtime requesters: I2S audio fetch, DFJK/background draw, line buffer and spares.
- Sits between those blocks and the bridge signal group `ar_*` (22-bit address, 16-bit byte enable, 128-bit data).
- Until `init_done`, only the loader is served.
- After `init_done`, port 0 (audio) has absolute priority; ports 1..N-1 are served round-robin.

Parameters:
- NPORT, 4, number of runtime requesters; 2..8. Port 0 is the urgent (audio) port.
- AW, 22, bridge address width.
- DW, 128, bridge data width.
- STARVE_MAX, 1023, starvation limit in clk cycles (optional feature only).

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high
- init_done  in  1  loader finished; level
- init_we  in  1  loader write request; held until init_ac
- init_addr  in  AW  loader word address
- init_wrdata  in  DW  loader write data
- init_ac  out  1  one-cycle completion pulse to loader
- req_rd  in  NPORT  per-port read request; held until ac
- req_wr  in  NPORT  per-port write request; held until ac
- req_addr  in  NPORT*AW  packed per-port addresses
- req_be  in  NPORT*16  packed per-port byte enables
- req_wrdata  in  NPORT*DW  packed per-port write data
- req_ac  out  NPORT  one-cycle completion pulse, one-hot
- req_wait  out  NPORT  request pending but not yet completed
- rd_data  out  DW  registered read data, valid on the req_ac pulse cycle and held until the next read
- ar_addr  out  AW  bridge address
- ar_be  out  16  bridge byte enable
- ar_read  out  1  bridge read strobe
- ar_write  out  1  bridge write strobe
- ar_wrdata  out  DW  bridge write data
- ar_ac  in  1  bridge acknowledge
- ar_rddata  in  DW  bridge read data, valid with ar_ac
- proto_err  out  1  sticky: a port asserted rd and wr together

Behaviour:
- Reset state: all outputs 0, FSM = IDLE, rr_ptr = 1, proto_err = 0. Reset applies on any cycle, including while a bridge access is in flight. Strobes drop the next edge; the in-flight ack is discarded and requesters must reissue.
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: strobe held; wait for ar_ac.
  - RECOVER: one cycle, so requesters can drop their request after the ac pulse.
- IDLE, init_done=0:
  - Only init_we is considered; grant the loader.
  - Latch ar_addr=init_addr, ar_wrdata=init_wrdata, ar_be=16'hFFFF.
  - ar_write=1 next cycle.
- IDLE, init_done=1, selection order:
  1. Port 0 if it requests.
  2. Otherwise the first requesting port scanning rr_ptr, rr_ptr+1, ... over 1..NPORT-1 with wrap. rr_ptr advances to granted+1, wrapping NPORT-1 -> 1.
  - init_we is ignored once init_done=1.
- On grant:
  - Address, be and wrdata are latched into the `ar_*` registers.
  - ar_read or ar_write is asserted in the cycle after the request is sampled (1-cycle issue latency).
  - If rd and wr are both set, the access is a write and proto_err is set.
- ISSUE:
  - Strobe and latched fields stay stable until ar_ac=1.
  - On ar_ac:
    - Strobe drops the next edge.
    - Reads: rd_data <= ar_rddata.
    - Pulse req_ac[g] (or init_ac) for exactly one cycle, coincident with rd_data becoming valid.
    - Go to RECOVER.
- No ar_ac timeout: ISSUE waits indefinitely.
- RECOVER: no arbitration this cycle; return to IDLE. Minimum spacing between bridge accesses is therefore 3 cycles plus bridge latency.
- ar_ac arriving in IDLE or RECOVER is ignored.
- req_wait[i] = (req_rd[i] | req_wr[i]) & ~req_ac[i], registered with the same timing as req_ac. It is 1 from the cycle after the request appears until the ac cycle.
- Requests dropped before ac are a protocol violation. Once issued, the transfer still completes and its ac is still pulsed.

Optional Feature:
- Macro SDRAM_SCHED_STARVE_GUARD_EN.
- Defined:
  - Each port 1..NPORT-1 has a saturating wait counter. It counts while the port requests and is not granted, and clears on grant.
  - When a counter reaches STARVE_MAX, that port is granted ahead of port 0 at the next IDLE. If several ports have reached STARVE_MAX, the lowest index goes first.
- Undefined: counters are absent; port 0 priority is absolute.

Decomposition:
- Package sdram_sched_pkg holds:
  - typedef enum {IDLE, ISSUE, RECOVER} sched_state_t
  - localparams AW, DW, BE_ALL=16'hFFFF
  - typedef struct {addr, be, wrdata, is_wr} sdram_cmd_t
- Sub-module rr_pick: combinational round-robin selector. Inputs: request vector and rr_ptr. Outputs: one-hot grant and valid.

Test Plan:
1. init_done=0, init_we with addr 22'h000010, data 128'hA5...; ar_ac 4 cycles after strobe -> ar_write=1, ar_be=FFFF, init_ac one pulse; runtime req_rd[1] ignored throughout.
2. init_done=1; req_rd[0] and req_rd[2] asserted in the same cycle -> port 0 served first, port 2 next. Check rd_data=ar_rddata on each req_ac.
3. Ports 1,2,3 requesting continuously with bridge ack after 1 cycle -> grant order 1,2,3,1,2,3; rr_ptr wraps 3 -> 1.
4. req_rd[1] and req_wr[1] both asserted -> access issued as ar_write; proto_err=1 and stays 1 until reset.
5. reset asserted during ISSUE -> ar_read=0 and req_ac=0 next cycle; no stale ac after reset release; a reissued request completes normally.
6. SDRAM_SCHED_STARVE_GUARD_EN, STARVE_MAX=8, port 0 requesting continuously, port 1 requesting -> port 1 granted once its counter reaches 8; without the macro port 1 is never granted.
